// File: rtl/my_udp_send.sv
// UDP/IPv4 frame transmitter onto the MII nibble interface.
// Builds preamble, Ethernet/IPv4/UDP headers, padded payload and FCS.
module my_udp_send #(
    parameter logic [47:0] BOARD_MAC  = 48'h12_34_56_78_9a_bc,
    parameter logic [31:0] BOARD_IP   = 32'hA9_FE_01_17,
    parameter logic [15:0] BOARD_PORT = 16'd1234,
    parameter logic [47:0] DES_MAC    = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] DES_IP     = 32'hA9_FE_01_01,
    parameter logic [15:0] DES_PORT   = 16'd1234
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        send_en,
    input  logic [15:0] send_data_num,
    input  logic [31:0] send_data,
    output logic        read_data_req,
    output logic        send_end,
    output logic        eth_tx_en,
    output logic [3:0]  eth_tx_data
);

    typedef enum logic [3:0] {
        IDLE, CHECK_SUM, PACKET_HEAD, ETH_HEAD, IP_HEAD,
        UDP_HEAD, SEND_DATA, CRC_TX, GAP
    } state_t;

    localparam logic [31:0]  POLY    = 32'hEDB88320;
    localparam logic [111:0] ETH_HDR = {DES_MAC, BOARD_MAC, 16'h0800};

    state_t      state, next_state;
    logic [11:0] cnt, state_end, data_end;
    logic [10:0] n_bytes, n_clamp, n_pad, b;
    logic        ph, tx_act, crc_act, crc_upd;
    logic [15:0] ip_len, udp_len, ip_id, csum;
    logic [31:0] acc, crc, data_reg, word, word_sh;
    logic [111:0] eth_sh;
    logic [159:0] ip_sh;
    logic [63:0]  udp_sh;
    logic [7:0]  cur_byte;
    logic [3:0]  nib;

    // Reflected CRC32, one nibble, bit 0 of the nibble first on the wire
    function automatic logic [31:0] crc_nib(input logic [31:0] c,
                                            input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++)
            r = {1'b0, r[31:1]} ^ ({32{r[0] ^ d[i]}} & POLY);
        return r;
    endfunction

    assign b  = cnt[11:1];
    assign ph = cnt[0];
    assign n_clamp = (send_data_num > 16'd1472) ? 11'd1472 : send_data_num[10:0];
    assign n_pad   = (n_clamp < 11'd18) ? 11'd18 : n_clamp;

    assign tx_act  = (state >= PACKET_HEAD) && (state <= CRC_TX);
    assign crc_upd = (state >= ETH_HEAD) && (state <= SEND_DATA);
    assign crc_act = (state == CRC_TX);

    always_comb begin
        state_end = 12'd0;
        unique case (state)
            CHECK_SUM:   state_end = 12'd2;
            PACKET_HEAD: state_end = 12'd15;
            ETH_HEAD:    state_end = 12'd27;
            IP_HEAD:     state_end = 12'd39;
            UDP_HEAD:    state_end = 12'd15;
            SEND_DATA:   state_end = data_end;
            CRC_TX:      state_end = 12'd7;
            GAP:         state_end = 12'd23;
            default:     state_end = 12'd0;
        endcase
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:        if (send_en) next_state = CHECK_SUM;
            CHECK_SUM:   if (cnt == state_end) next_state = PACKET_HEAD;
            PACKET_HEAD: if (cnt == state_end) next_state = ETH_HEAD;
            ETH_HEAD:    if (cnt == state_end) next_state = IP_HEAD;
            IP_HEAD:     if (cnt == state_end) next_state = UDP_HEAD;
            UDP_HEAD:    if (cnt == state_end) next_state = SEND_DATA;
            SEND_DATA:   if (cnt == state_end) next_state = CRC_TX;
            CRC_TX:      if (cnt == state_end) next_state = GAP;
            GAP:         if (cnt == state_end) next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // The first byte of each word is taken straight from send_data on its capture cycle
    always_comb begin
        eth_sh   = ETH_HDR << {b, 3'b0};
        ip_sh    = {16'h4500, ip_len, ip_id, 16'h4000, 16'h4011, csum,
                    BOARD_IP, DES_IP} << {b, 3'b0};
        udp_sh   = {BOARD_PORT, DES_PORT, udp_len, 16'h0000} << {b, 3'b0};
        word     = (b[1:0] == 2'd0 && !ph) ? send_data : data_reg;
        word_sh  = word << {b[1:0], 3'b0};
        cur_byte = 8'h00;
        unique case (state)
            PACKET_HEAD: cur_byte = (b == 11'd7) ? 8'hD5 : 8'h55;
            ETH_HEAD:    cur_byte = eth_sh[111:104];
            IP_HEAD:     cur_byte = ip_sh[159:152];
            UDP_HEAD:    cur_byte = udp_sh[63:56];
            SEND_DATA:   cur_byte = (b < n_bytes) ? word_sh[31:24] : 8'h00;
            default:     cur_byte = 8'h00;
        endcase
        nib = crc_act ? ~crc[3:0] : (ph ? cur_byte[7:4] : cur_byte[3:0]);
    end

    assign read_data_req =
        (state == UDP_HEAD && cnt == 12'd15 && n_bytes != 11'd0) ||
        (state == SEND_DATA && b[1:0] == 2'd3 && ph &&
         ({1'b0, b} + 12'd1) < {1'b0, n_bytes});

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            cnt   <= 12'd0;
        end else begin
            state <= next_state;
            if (next_state != state || state == IDLE) cnt <= 12'd0;
            else                                       cnt <= cnt + 12'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            n_bytes     <= 11'd0;
            data_end    <= 12'd0;
            ip_len      <= 16'd0;
            udp_len     <= 16'd0;
            ip_id       <= 16'd0;
            csum        <= 16'd0;
            acc         <= 32'd0;
            crc         <= '1;
            data_reg    <= 32'd0;
            eth_tx_en   <= 1'b0;
            eth_tx_data <= 4'd0;
            send_end    <= 1'b0;
        end else begin
            if (state == IDLE && send_en) begin
                n_bytes  <= n_clamp;
                data_end <= {n_pad - 11'd1, 1'b1};
                ip_len   <= 16'd28 + 16'(n_clamp);
                udp_len  <= 16'd8 + 16'(n_clamp);
            end
            if (state == CHECK_SUM) begin
                unique case (cnt[1:0])
                    2'd0: acc <= 32'h4500 + 32'(ip_len) + 32'(ip_id) + 32'h4000
                               + 32'h4011 + 32'(BOARD_IP[31:16]) + 32'(BOARD_IP[15:0])
                               + 32'(DES_IP[31:16]) + 32'(DES_IP[15:0]);
                    2'd1: acc <= 32'(acc[31:16]) + 32'(acc[15:0]);
                    default: csum <= ~(acc[31:16] + acc[15:0]);
                endcase
            end
            if (crc_upd)      crc <= crc_nib(crc, nib);
            else if (crc_act) crc <= {4'hF, crc[31:4]};
            else              crc <= '1;
            if (state == SEND_DATA && b[1:0] == 2'd0 && !ph)
                data_reg <= send_data;
            eth_tx_en   <= tx_act;
            eth_tx_data <= tx_act ? nib : 4'd0;
            send_end    <= (state == GAP && cnt == 12'd0);
            if (state == GAP && cnt == 12'd0)
                ip_id <= ip_id + 16'd1;
        end
    end

endmodule
